// File: rtl/st_frame_packetizer.sv
// st_frame_packetizer
//   Frames an unframed valid/ready sample stream into fixed-length
//   Avalon-ST packets of FRAME_LEN beats with startofpacket/endofpacket.
//   Framing starts and stops only on frame boundaries under `enable`.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   enable              - level; high = produce frames, low = stop at boundary
//   in_valid/in_ready   - input handshake; in_data is the sample
//   out_valid/out_ready - output handshake (ready latency 0), registered
//   out_data            - registered output sample
//   out_startofpacket   - first beat of a frame (registered)
//   out_endofpacket     - last beat of a frame (registered)
//   busy                - high while in RUN or STOPPING
//   frame_count         - completed frames (counted at eop load), wraps
module st_frame_packetizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] index;
    logic [CNT_WIDTH-1:0] index_nxt;
    logic                 load;
    logic                 last;

    // Accept whenever framing is active and the single output slot is
    // empty or being drained this cycle, so full throughput has no bubble.
    assign in_ready = (state != IDLE) && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;
    assign last     = (index == LAST_IDX);
    assign busy     = (state != IDLE);

    always_comb begin
        index_nxt = index;
        if (load) begin
            index_nxt = last ? '0 : index + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            index             <= '0;
            frame_count       <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else begin
            if (load) begin
                out_valid         <= 1'b1;
                out_data          <= in_data;
                out_startofpacket <= (index == '0);
                out_endofpacket   <= last;
                index             <= index_nxt;
                if (last) begin
                    frame_count <= frame_count + CNT_WIDTH'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Decisions use the post-load index so that enable falling on
            // the eop load goes straight to IDLE, and a STOPPING frame
            // ends exactly when its eop beat loads.
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (index_nxt == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= STOPPING;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_st_frame_packetizer.sv
// Directed testbench for st_frame_packetizer (FRAME_LEN=4, CNT_WIDTH=4).
module tb_st_frame_packetizer;

    localparam int unsigned DW = 16;
    localparam int unsigned FL = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic          busy;
    logic [CW-1:0] frame_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    st_frame_packetizer #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    int            sent;
    int            rcv;
    int            cyc;

    initial begin
        // ---------------- reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sop", 32'(out_startofpacket), 32'd0);
        chk("rst_eop", 32'(out_endofpacket), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);

        // ---------------- 1: full throughput, two frames
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            #1;
            chk("t1_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("t1_out_valid", 32'(out_valid), 32'd1);
            chk("t1_out_data", 32'(out_data), 32'(i));
            chk("t1_sop", 32'(out_startofpacket), 32'((i % 4) == 1));
            chk("t1_eop", 32'(out_endofpacket), 32'((i % 4) == 0));
        end
        in_valid = 1'b0;
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);
        chk("t1_frame_count", 32'(frame_count), 32'd2);

        // ---------------- 2: backpressure holds the first beat
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = DW'(1);
        tick();
        out_ready = 1'b0;
        in_data   = DW'(2);
        #1;
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_data", 32'(out_data), 32'd1);
            chk("t2_hold_sop", 32'(out_startofpacket), 32'd1);
            chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_in_ready_resume", 32'(in_ready), 32'd1);
        tick();
        chk("t2_beat2_data", 32'(out_data), 32'd2);
        chk("t2_beat2_sop", 32'(out_startofpacket), 32'd0);
        in_data = DW'(3);
        tick();
        chk("t2_beat3_data", 32'(out_data), 32'd3);
        in_data = DW'(4);
        tick();
        chk("t2_beat4_data", 32'(out_data), 32'd4);
        chk("t2_beat4_eop", 32'(out_endofpacket), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("t2_frame_count", 32'(frame_count), 32'd1);

        // ---------------- 3: enable dropped mid-frame finishes the frame
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = DW'(1);
        tick();
        in_data = DW'(2);
        tick();
        enable  = 1'b0;
        in_data = DW'(3);
        #1;
        chk("t3_in_ready_b3", 32'(in_ready), 32'd1);
        tick();
        chk("t3_b3_data", 32'(out_data), 32'd3);
        chk("t3_stopping_busy", 32'(busy), 32'd1);
        in_data = DW'(4);
        #1;
        chk("t3_in_ready_b4", 32'(in_ready), 32'd1);
        tick();
        chk("t3_b4_data", 32'(out_data), 32'd4);
        chk("t3_b4_eop", 32'(out_endofpacket), 32'd1);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        chk("t3_idle_in_ready", 32'(in_ready), 32'd0);
        chk("t3_frame_count", 32'(frame_count), 32'd1);
        in_data = DW'(5);
        tick();
        chk("t3_no_load_idle", 32'(out_valid), 32'd0);
        chk("t3_idle_stays", 32'(busy), 32'd0);
        in_valid = 1'b0;

        // ---------------- 4: random handshakes, 200 samples
        do_reset();
        enable = 1'b1;
        tick();
        q.delete();
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while ((rcv < 200) && (cyc < 4000)) begin
            in_valid  = (sent < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("t4_unexpected_beat", 32'(q.size()), 32'd1);
                end else begin
                    exp_d = q.pop_front();
                    chk("t4_data", 32'(out_data), 32'(exp_d));
                    chk("t4_sop", 32'(out_startofpacket), 32'((rcv % 4) == 0));
                    chk("t4_eop", 32'(out_endofpacket), 32'((rcv % 4) == 3));
                end
                rcv++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("t4_received", 32'(rcv), 32'd200);
        chk("t4_frame_count", 32'(frame_count), 32'(50 % 16));

        // ---------------- 5: reset mid-frame
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = DW'(1);
        tick();
        in_data = DW'(2);
        tick();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_frame_count", 32'(frame_count), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        in_data = DW'(9);
        tick();
        chk("t5_no_load_idle", 32'(out_valid), 32'd0);
        chk("t5_run_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_first_data", 32'(out_data), 32'd9);
        chk("t5_first_sop", 32'(out_startofpacket), 32'd1);
        in_valid = 1'b0;

        // ---------------- 6: frame_count wrap (CNT_WIDTH=4)
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_data = DW'(i);
            tick();
        end
        chk("t6_count_15", 32'(frame_count), 32'd15);
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(100 + i);
            tick();
            if (i == 0) begin
                chk("t6_next_sop", 32'(out_startofpacket), 32'd1);
            end
        end
        chk("t6_count_wrap", 32'(frame_count), 32'd0);
        chk("t6_last_eop", 32'(out_endofpacket), 32'd1);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
